// File: rtl/fifo_word_unpacker_pkg.sv
// Shared definitions for the FIFO word unpacker.
//   state_t   : FSM state encoding (2-bit), also exported as a debug output
//   DEF_DW/BW : default word and beat widths
//   cnt_width : beat-counter width for a given beats-per-word count
package fifo_word_unpacker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_BW = 8;

  // clog2(beats), but never zero so a one-beat word still has a legal counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// Bundle of the FIFO read port and the outgoing beat stream.
//   fifo_rdata/fifo_empty : from the FIFO (rdata valid the cycle after fifo_ren)
//   fifo_ren              : one-cycle pop strobe to the FIFO
//   m_valid/m_ready       : beat stream handshake
//   m_data/m_last         : beat payload and end-of-word marker
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready.
// Once m_valid is high, m_valid, m_data and m_last hold until that transfer;
// m_valid never drops without a transfer except on reset. The master side is
// the unpacker; the slave side is the FIFO plus the byte sink.
interface fifo_word_unpacker_if #(
  parameter int DW = fifo_word_unpacker_pkg::DEF_DW,
  parameter int BW = fifo_word_unpacker_pkg::DEF_BW
);
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          fifo_ren;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;

  modport master (
    input  fifo_rdata, fifo_empty, m_ready,
    output fifo_ren, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_rdata, fifo_empty, m_ready,
    input  fifo_ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_word_unpacker_word_beat_shifter.sv
// Holds one FIFO word and presents it one BW-bit beat at a time.
//   load    : capture word_in, restart at beat 0
//   advance : step to the next beat (wraps to 0 after the last)
//   beat    : currently selected beat
//   last    : current beat is the final one of the word
module word_beat_shifter
  import fifo_word_unpacker_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int BW        = DEF_BW,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] word_in,
  input  logic          advance,
  output logic [BW-1:0] beat,
  output logic          last
);
  localparam int BEATS = DW / BW;
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [DW-1:0] word;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sel;
  logic [DW-1:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= word_in;
      cnt  <= '0;
    end else if (advance) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  // MSB-first counts beat slots down from the top of the word.
  always_comb begin
    sel     = MSB_FIRST ? (LAST_IDX - cnt) : cnt;
    shifted = word >> (int'(sel) * BW);
    beat    = shifted[BW-1:0];
  end

  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/fifo_word_unpacker.sv
// Read-side consumer of the async FIFO. Pops one word at a time, splits it
// into DW/BW beats and streams them out with valid/ready.
//   clk, rst  : read clock, async active-high reset
//   bus       : FIFO read port + beat stream (master modport)
//   busy      : FSM is not in IDLE
//   dbg_state : current FSM state
module fifo_word_unpacker
  import fifo_word_unpacker_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int BW        = DEF_BW,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_word_unpacker_if.master  bus,
  output logic                  busy,
  output state_t                dbg_state
);
  if (BW < 1 || (DW % BW) != 0) begin : g_bad_width
    $error("fifo_word_unpacker: DW must be a positive multiple of BW");
  end

  state_t        state;
  logic          hs;
  logic          last_beat;
  logic [BW-1:0] beat;

  assign hs = (state == S_SEND) && bus.m_valid && bus.m_ready;

  // Fast path: the final beat's handshake pops the next word in the same
  // cycle, so only WAIT sits between words. POP is entered only after IDLE
  // saw the FIFO non-empty, and nothing else pops, so it is still non-empty.
  assign bus.fifo_ren = (state == S_POP) ||
                        (hs && last_beat && !bus.fifo_empty);

  // Beat lines read as zero whenever no beat is offered.
  assign bus.m_data = bus.m_valid ? beat : '0;
  assign bus.m_last = bus.m_valid && last_beat;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bus.m_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!bus.fifo_empty) state <= S_POP;
        S_POP:  state <= S_WAIT;
        S_WAIT: begin
          state       <= S_SEND;
          bus.m_valid <= 1'b1;
        end
        S_SEND: if (hs && last_beat) begin
          bus.m_valid <= 1'b0;
          state       <= bus.fifo_empty ? S_IDLE : S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  word_beat_shifter #(
    .DW(DW), .BW(BW), .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_WAIT),
    .word_in (bus.fifo_rdata),
    .advance (hs),
    .beat    (beat),
    .last    (last_beat)
  );

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: MSB-first instance with a queue FIFO model and
// scoreboard, plus an LSB-first instance for beat ordering.
module tb_fifo_word_unpacker;
  import fifo_word_unpacker_pkg::*;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int BEATS = DW / BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_word_unpacker_if #(.DW(DW), .BW(BW)) bus_a ();
  fifo_word_unpacker_if #(.DW(DW), .BW(BW)) bus_b ();
  logic   busy_a, busy_b;
  state_t st_a, st_b;

  fifo_word_unpacker #(.DW(DW), .BW(BW), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .dbg_state(st_a)
  );
  fifo_word_unpacker #(.DW(DW), .BW(BW), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .dbg_state(st_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO models (registered empty, rdata after ren) ----------------
  logic [DW-1:0] fq_a[$];
  logic [DW-1:0] fq_b[$];
  int pops_a = 0;
  int na, nb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_a.fifo_empty <= 1'b1;
      bus_a.fifo_rdata <= '0;
    end else begin
      na = fq_a.size();
      if (bus_a.fifo_ren && na > 0) begin
        bus_a.fifo_rdata <= fq_a.pop_front();
        na--;
        pops_a++;
      end
      bus_a.fifo_empty <= (na == 0);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_b.fifo_empty <= 1'b1;
      bus_b.fifo_rdata <= '0;
    end else begin
      nb = fq_b.size();
      if (bus_b.fifo_ren && nb > 0) begin
        bus_b.fifo_rdata <= fq_b.pop_front();
        nb--;
      end
      bus_b.fifo_empty <= (nb == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic          exp_last_q[$];

  // Expected beats straight from the word: MSB-first, top byte out first.
  task automatic push_a(input logic [DW-1:0] w);
    logic [DW-1:0] t;
    fq_a.push_back(w);
    for (int k = 0; k < BEATS; k++) begin
      t = w >> (DW - BW * (k + 1));
      exp_q.push_back(t[BW-1:0]);
      exp_last_q.push_back(k == BEATS - 1);
    end
  endtask

  // Handshake log for instance A
  logic [BW-1:0] hs_data[$];
  logic          hs_last[$];
  int            hs_cyc[$];
  logic          hs_ren[$];
  int   ren_cnt = 0;
  int   fall_cyc = 0, rise_cyc = 0;
  logic empty_prev = 1'b1, valid_prev = 1'b0, stall_prev = 1'b0;
  logic [BW-1:0] data_prev = '0;

  task automatic clear_log();
    hs_data.delete(); hs_last.delete(); hs_cyc.delete(); hs_ren.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      valid_prev = 1'b0;
      empty_prev = 1'b1;
    end else begin
      if (bus_a.fifo_ren) begin
        ren_cnt++;
        check("pop_while_empty", bus_a.fifo_empty, 1'b0);
      end
      if (empty_prev && !bus_a.fifo_empty) fall_cyc = cyc;
      if (!valid_prev && bus_a.m_valid) rise_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", bus_a.m_valid, 1'b1);
        check("stall_data", bus_a.m_data, data_prev);
      end
      if (bus_a.m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus_a.m_valid, 1'b0);
        end else begin
          check("beat_data", bus_a.m_data, exp_q[0]);
          check("beat_last", bus_a.m_last, exp_last_q[0]);
          if (bus_a.m_ready) begin
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
        if (bus_a.m_ready) begin
          hs_data.push_back(bus_a.m_data);
          hs_last.push_back(bus_a.m_last);
          hs_cyc.push_back(cyc);
          hs_ren.push_back(bus_a.fifo_ren);
        end
      end
      stall_prev = bus_a.m_valid && !bus_a.m_ready;
      data_prev  = bus_a.m_data;
      valid_prev = bus_a.m_valid;
      empty_prev = bus_a.fifo_empty;
    end
  end

  // Handshake log for instance B
  logic [BW-1:0] hsb_data[$];
  logic          hsb_last[$];
  always @(negedge clk) begin
    if (!rst && bus_b.m_valid && bus_b.m_ready) begin
      hsb_data.push_back(bus_b.m_data);
      hsb_last.push_back(bus_b.m_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string name, input int bound);
    int n = 0;
    while (!(fq_a.size() == 0 && exp_q.size() == 0 && !busy_a) && n < bound) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= bound) begin
      tests_failed++;
      $display("FAIL timeout %s: still busy after %0d cycles, limit %0d", name, n, bound);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_valid"}, bus_a.m_valid, 1'b0);
    check({tag, "_fifo_ren"}, bus_a.fifo_ren, 1'b0);
    check({tag, "_m_data"}, bus_a.m_data, '0);
    check({tag, "_m_last"}, bus_a.m_last, 1'b0);
    check({tag, "_busy"}, busy_a, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int p0, r0, n;

  initial begin
    bus_a.m_ready = 1'b0;
    bus_b.m_ready = 1'b0;

    // Reset state
    step();
    check_outputs_zero("reset");
    check("reset_state", st_a, S_IDLE);
    step();
    rst = 1'b0;

    // FIFO empty throughout: nothing moves
    bus_a.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("empty_ren", bus_a.fifo_ren, 1'b0);
      check("empty_valid", bus_a.m_valid, 1'b0);
      check("empty_busy", busy_a, 1'b0);
    end

    // Single word, MSB first, latency from fifo_empty falling
    clear_log();
    r0 = ren_cnt;
    p0 = pops_a;
    push_a(32'h11223344);
    wait_done_a("single_word", 60);
    check("single_beats", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      check("single_b0", hs_data[0], 8'h11);
      check("single_b1", hs_data[1], 8'h22);
      check("single_b2", hs_data[2], 8'h33);
      check("single_b3", hs_data[3], 8'h44);
      check("single_last3", hs_last[3], 1'b1);
      check("single_last0", hs_last[0], 1'b0);
    end
    check("single_ren_pulses", ren_cnt - r0, 1);
    check("single_pops", pops_a - p0, 1);
    check("single_latency", rise_cyc - fall_cyc, 3);

    // Two words back to back: one bubble, fast-path pop on the EF handshake
    clear_log();
    r0 = ren_cnt;
    push_a(32'hDEADBEEF);
    push_a(32'h01020304);
    wait_done_a("two_words", 80);
    check("two_beats", hs_data.size(), 8);
    if (hs_data.size() == 8) begin
      check("two_b3", hs_data[3], 8'hEF);
      check("two_b4", hs_data[4], 8'h01);
      check("two_in_word_span", hs_cyc[3] - hs_cyc[0], 3);
      check("two_bubble", hs_cyc[4] - hs_cyc[3], 2);
      check("two_fast_ren", hs_ren[3], 1'b1);
    end
    check("two_ren_pulses", ren_cnt - r0, 2);

    // Reset mid-SEND: partial word discarded, next word fresh
    clear_log();
    push_a(32'hA1B2C3D4);
    n = 0;
    while (hs_data.size() < 1 && n < 40) begin step(); n++; end
    check("midword_reached", hs_data.size(), 1);
    bus_a.m_ready = 1'b0;
    step();
    check("midword_beat1", bus_a.m_data, 8'hB2);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    step();
    check_outputs_zero("midreset_edge");
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    clear_log();
    bus_a.m_ready = 1'b1;
    push_a(32'h55667788);
    wait_done_a("after_reset", 60);
    check("after_reset_beats", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      check("after_reset_b0", hs_data[0], 8'h55);
      check("after_reset_b3", hs_data[3], 8'h88);
    end

    // Random backpressure, 100 words
    clear_log();
    p0 = pops_a;
    for (int i = 0; i < 100; i++) push_a($urandom());
    n = 0;
    while (!(fq_a.size() == 0 && exp_q.size() == 0 && !busy_a) && n < 4000) begin
      bus_a.m_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus_a.m_ready = 1'b1;
    wait_done_a("random_stream", 200);
    check("random_pops", pops_a - p0, 100);
    check("random_beats", hs_data.size(), 400);
    check("random_leftover", exp_q.size(), 0);

    // LSB-first instance
    bus_b.m_ready = 1'b1;
    fq_b.push_back(32'h11223344);
    n = 0;
    while (hsb_data.size() < 4 && n < 60) begin step(); n++; end
    check("lsb_beats", hsb_data.size(), 4);
    if (hsb_data.size() == 4) begin
      check("lsb_b0", hsb_data[0], 8'h44);
      check("lsb_b1", hsb_data[1], 8'h33);
      check("lsb_b2", hsb_data[2], 8'h22);
      check("lsb_b3", hsb_data[3], 8'h11);
      check("lsb_last3", hsb_last[3], 1'b1);
    end
    repeat (4) step();
    check("lsb_idle", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
